// File: rtl/avalon_ibex_pkg.sv
// ---------------------------------------------------------------------------
// avalon_ibex_pkg
//
// Shared types for the Avalon-MM slave to ibex-style memory bridge.
//   avs_response_e : Avalon response codes carried on avs_response.
//   txn_type_e     : kind of transaction held in the in-order tracking FIFO.
//   resp_from_err  : maps the memory-side error flag to an Avalon response.
// ---------------------------------------------------------------------------
package avalon_ibex_pkg;

    typedef enum logic [1:0] {
        OKAY        = 2'b00,
        RESERVED    = 2'b01,
        SLVERR      = 2'b10,
        DECODEERROR = 2'b11
    } avs_response_e;

    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_type_e;

    // The memory side only reports pass/fail, so only OKAY and SLVERR are
    // ever produced by the bridge.
    function automatic avs_response_e resp_from_err(input logic err);
        return err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/avalon_ibex_txn_fifo.sv
// ---------------------------------------------------------------------------
// avalon_ibex_txn_fifo
//
// In-order record of transactions that were granted on the memory side but
// have not yet seen their rvalid. Each entry holds only the transaction type,
// which decides what Avalon response the matching rvalid produces.
//
// Parameters
//   Depth        : number of entries (maximum outstanding transactions).
//
// Ports
//   clk_i        : clock, rising edge.
//   rst_i        : synchronous active-high reset; empties the FIFO.
//   push_i       : record a new transaction of type push_type_i.
//   push_type_i  : type of the transaction being recorded.
//   pop_i        : retire the oldest entry (ignored while empty).
//   head_type_o  : type of the oldest entry (meaningful while !empty_o).
//   full_o       : Depth entries held.
//   empty_o      : no entries held.
//   count_o      : number of entries held.
// ---------------------------------------------------------------------------
module avalon_ibex_txn_fifo
    import avalon_ibex_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  txn_type_e                    push_type_i,
    input  logic                         pop_i,
    output txn_type_e                    head_type_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    txn_type_e       slots [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only safe when an entry leaves on the same edge.
    assign do_push = push_i & (~full_o | do_pop);

    assign full_o      = (count_o == CntW'(Depth));
    assign empty_o     = (count_o == '0);
    assign head_type_o = slots[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + CntW'(1);
                2'b01:   count_o <= count_o - CntW'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            slots[wr_ptr] <= push_type_i;
        end
    end

endmodule

// File: rtl/avalon_ibex_responder_main.sv
// ---------------------------------------------------------------------------
// avalon_ibex_responder_main
//
// Bridges an Avalon-MM slave port (pipelined reads, posted writes) onto an
// ibex-style req/gnt/rvalid memory port. Requests pass through
// combinationally; accepted transactions are tracked in order so every
// memory rvalid can be matched to its read or write.
//
// Configuration macro: AVS_WRITE_RESP_EN
//   defined   : adds avs_writeresponsevalid, pulsed one cycle after the
//               rvalid of a write, with avs_response carrying its status.
//   undefined : writes are posted; their rvalids produce no Avalon response.
//
// Parameters
//   MaxOutstanding : accepted-but-unanswered transactions allowed (2..16).
//   WordAddr       : 1 = avs_address is a word address, 0 = byte address.
//
// Ports
//   clk_i, rst_i                      : clock, synchronous active-high reset.
//   avs_address, avs_byteenable,
//   avs_read, avs_write,
//   avs_writedata                     : Avalon request.
//   avs_waitrequest                   : Avalon stall.
//   avs_readdata, avs_readdatavalid,
//   avs_response                      : Avalon read response.
//   mem_req_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o           : ibex-style request.
//   mem_gnt_i, mem_rvalid_i,
//   mem_err_i, mem_rdata_i            : ibex-style grant / response.
//   err_sticky_o                      : set by any error response, cleared
//                                       only by reset.
//   avs_writeresponsevalid            : only with AVS_WRITE_RESP_EN.
//
// Handshake: a transaction is accepted on a rising edge where
// mem_req_o & mem_gnt_i is high, which is exactly the edge where an Avalon
// strobe is high with avs_waitrequest low; the master holds its request
// while avs_waitrequest is high. Responses have no back-pressure: every
// mem_rvalid_i retires the oldest accepted transaction, and a read's data
// appears on avs_readdata with avs_readdatavalid one cycle later.
// ---------------------------------------------------------------------------
module avalon_ibex_responder_main
    import avalon_ibex_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter bit WordAddr       = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] avs_address,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [1:0]  avs_response,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_sticky_o
`ifdef AVS_WRITE_RESP_EN
    ,
    output logic        avs_writeresponsevalid
`endif
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic            strobe;
    logic            accept;
    logic            pop;
    logic            pop_read;
    logic            resp_update;
    logic            fifo_full;
    logic            fifo_empty;
    txn_type_e       head_type;
    txn_type_e       push_type;
    logic [CntW-1:0] txn_count;
    avs_response_e   resp_q;

    // -----------------------------------------------------------------------
    // Request path (combinational)
    // -----------------------------------------------------------------------
    assign strobe    = avs_read | avs_write;
    assign mem_req_o = strobe & ~fifo_full;
    // Read wins when both strobes are high; the write is dropped.
    assign mem_we_o  = avs_write & ~avs_read;
    assign push_type = avs_read ? TXN_READ : TXN_WRITE;

    assign mem_addr_o  = WordAddr ? {avs_address[29:0], 2'b00}
                                  : {avs_address[31:2], 2'b00};
    assign mem_be_o    = avs_byteenable;
    assign mem_wdata_o = avs_writedata;

    assign accept          = mem_req_o & mem_gnt_i;
    assign avs_waitrequest = strobe ? ~accept : 1'b1;

    // -----------------------------------------------------------------------
    // Transaction tracking
    // -----------------------------------------------------------------------
    // An rvalid with nothing outstanding (e.g. left over from before a reset)
    // is not a response to anything and is dropped here.
    assign pop      = mem_rvalid_i & ~fifo_empty;
    assign pop_read = pop & (head_type == TXN_READ);

    avalon_ibex_txn_fifo #(
        .Depth (MaxOutstanding)
    ) u_txn_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_type_i (push_type),
        .pop_i       (pop),
        .head_type_o (head_type),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (txn_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (txn_count <= CntW'(MaxOutstanding));
        end
    end

    // -----------------------------------------------------------------------
    // Response path (registered, one cycle after the memory rvalid)
    // -----------------------------------------------------------------------
`ifdef AVS_WRITE_RESP_EN
    assign resp_update = pop;
`else
    // Posted writes leave avs_response untouched.
    assign resp_update = pop_read;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            resp_q            <= OKAY;
            err_sticky_o      <= 1'b0;
        end else begin
            avs_readdatavalid <= pop_read;
            // readdata holds its last value between read responses.
            if (pop_read) begin
                avs_readdata <= mem_rdata_i;
            end
            if (resp_update) begin
                resp_q <= resp_from_err(mem_err_i);
            end
            if (pop & mem_err_i) begin
                err_sticky_o <= 1'b1;
            end
        end
    end

`ifdef AVS_WRITE_RESP_EN
    // Only one FIFO entry pops per cycle, so this never coincides with
    // avs_readdatavalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            avs_writeresponsevalid <= 1'b0;
        end else begin
            avs_writeresponsevalid <= pop & (head_type == TXN_WRITE);
        end
    end
`endif

    assign avs_response = resp_q;

endmodule

// File: tb/tb_avalon_ibex_responder_main.sv
module tb_avalon_ibex_responder_main;

  localparam int MAX_OUT = 4;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [31:0] avs_address = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [1:0]  avs_response;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_sticky_o;
`ifdef AVS_WRITE_RESP_EN
  logic        avs_writeresponsevalid;
`endif

  avalon_ibex_responder_main #(
    .MaxOutstanding (MAX_OUT),
    .WordAddr       (1'b1)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .avs_address       (avs_address),
    .avs_byteenable    (avs_byteenable),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_response      (avs_response),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_be_o          (mem_be_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_err_i         (mem_err_i),
    .mem_rdata_i       (mem_rdata_i),
    .err_sticky_o      (err_sticky_o)
`ifdef AVS_WRITE_RESP_EN
    ,
    .avs_writeresponsevalid (avs_writeresponsevalid)
`endif
  );

  // ---------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int rdv_seen = 0;

  bit          out_q[$];   // outstanding transactions, 1 = read, oldest first
  logic [33:0] exp_q[$];   // expected read responses {resp, data}
  logic [1:0]  wexp_q[$];  // expected write responses (write-response build)
  logic [31:0] last_data = '0;
  bit          sticky = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    avs_read = 1'b0; avs_write = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    out_q.delete(); exp_q.delete(); wexp_q.delete();
    last_data = '0; sticky = 1'b0;
    check("rst_rdv", avs_readdatavalid, 1'b0);
    check("rst_rdata", avs_readdata, 32'h0);
    check("rst_resp", avs_response, 2'b00);
    check("rst_sticky", err_sticky_o, 1'b0);
    check("rst_waitreq", avs_waitrequest, 1'b1);
    check("rst_req", mem_req_o, 1'b0);
    rst_i = 1'b0;
  endtask

  // One bus cycle: drive, check the request side, advance the model, clock,
  // then check the registered response side.
  task automatic cycle(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input bit gnt,
                       input bit rv, input logic [31:0] rdata, input bit err);
    bit strobe;
    bit exp_req;
    bit is_rd;
    logic [33:0] e;
    avs_read = rd; avs_write = wr; avs_address = addr; avs_byteenable = be;
    avs_writedata = wd; mem_gnt_i = gnt; mem_rvalid_i = rv;
    mem_rdata_i = rdata; mem_err_i = err;
    #1;
    strobe  = rd | wr;
    exp_req = strobe && (out_q.size() < MAX_OUT);
    check("mem_req", mem_req_o, exp_req);
    check("mem_we", mem_we_o, wr && !rd);
    check("waitrequest", avs_waitrequest, strobe ? !(exp_req && gnt) : 1'b1);
    if (exp_req) begin
      check("mem_addr", mem_addr_o, addr << 2);
      check("mem_be", mem_be_o, be);
      check("mem_wdata", mem_wdata_o, wd);
    end
    if (rv && out_q.size() > 0) begin
      is_rd = out_q.pop_front();
      if (is_rd) exp_q.push_back({err ? 2'b10 : 2'b00, rdata});
      else wexp_q.push_back(err ? 2'b10 : 2'b00);
      if (err) sticky = 1'b1;
    end
    if (exp_req && gnt) out_q.push_back(rd);
    @(posedge clk_i); #1;
    if (avs_readdatavalid === 1'b1) rdv_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rdv", avs_readdatavalid, 1'b1);
      check("rdata", avs_readdata, e[31:0]);
      check("resp", avs_response, e[33:32]);
      last_data = e[31:0];
    end else begin
      check("rdv_idle", avs_readdatavalid, 1'b0);
      check("rdata_hold", avs_readdata, last_data);
    end
`ifdef AVS_WRITE_RESP_EN
    if (wexp_q.size() > 0) begin
      check("wrv", avs_writeresponsevalid, 1'b1);
      check("wresp", avs_response, wexp_q.pop_front());
    end else begin
      check("wrv_idle", avs_writeresponsevalid, 1'b0);
    end
`else
    wexp_q.delete();
`endif
    check("sticky", err_sticky_o, sticky);
  endtask

  task automatic idle(input bit rv, input logic [31:0] rdata, input bit err);
    cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, rv, rdata, err);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && out_q.size() > 0; k++) idle(1'b1, $urandom, 1'b0);
    check("drain_empty", out_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------
  // Directed steps, then randomized traffic
  // ---------------------------------------------------------------------
  initial begin
    int rdv_base;
    do_reset();

    // Single read, rvalid two cycles after grant, data one cycle later.
    cycle(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("r032_addr", mem_addr_o, 32'h40);
    idle(1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'hDEADBEEF, 1'b0);
    check("r032_rdv", avs_readdatavalid, 1'b1);
    check("r032_rdata", avs_readdata, 32'hDEADBEEF);
    check("r032_resp", avs_response, 2'b00);
    idle(1'b0, 32'h0, 1'b0);
    check("r032_hold", avs_readdata, 32'hDEADBEEF);

    // Four reads fill the tracker; the fifth stalls until the first rvalid.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h100 + i, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("r033_req", mem_req_o, 1'b0);
    check("r033_wait", avs_waitrequest, 1'b1);
    cycle(1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 1'b1, 1'b1, 32'h11111111, 1'b0);
    cycle(1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 1'b1, 1'b1, 32'h22222222, 1'b0);
    // Back-to-back rvalids give one read response per cycle.
    drain();

    // Posted write followed by a read: only the read answers.
    rdv_base = rdv_seen;
    cycle(1'b0, 1'b1, 32'h20, 4'b0011, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h21, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'hBAD0BAD0, 1'b0);
    idle(1'b1, 32'h12345678, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    check("r034_count", rdv_seen - rdv_base, 1);
    check("r034_rdata", avs_readdata, 32'h12345678);

    // Read and write strobes together: served as a read.
    cycle(1'b1, 1'b1, 32'h30, 4'hF, 32'h55555555, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'h0BADF00D, 1'b0);
    check("both_rdata", avs_readdata, 32'h0BADF00D);

    // Error response sets the sticky flag for good.
    cycle(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'hEEEEEEEE, 1'b1);
    check("r035_resp", avs_response, 2'b10);
    check("r035_sticky", err_sticky_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 32'h41 + i, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      idle(1'b1, 32'hA0A0A0A0 + i, 1'b0);
    end
    check("r035_okay", avs_response, 2'b00);
    check("r035_keep", err_sticky_o, 1'b1);

    // Reset with two reads outstanding, then stray rvalids.
    cycle(1'b1, 1'b0, 32'h50, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h51, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    do_reset();
    idle(1'b1, 32'h77777777, 1'b0);
    idle(1'b1, 32'h88888888, 1'b1);
    check("r036_rdata", avs_readdata, 32'h0);
    // Tracker really is empty: exactly four more reads fit before stalling.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h60 + i, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("r036_full", mem_req_o, 1'b0);
    drain();

    // Write with rvalid: response pulse only in the write-response build.
    cycle(1'b0, 1'b1, 32'h70, 4'hF, 32'h13579BDF, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'h0, 1'b0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 3);
      cycle(op == 1 || op == 3, op == 2 || op == 3, $urandom, 4'($urandom),
            $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom, $urandom_range(0, 15) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_ibex_responder_main.md
AVALON_IBEX_RESPONDER_MAIN -- requirements
Module: avalon_ibex_responder_main

Interface
REQ-001 SHALL provide parameter MaxOutstanding, default 4, max accepted-but-unanswered transactions (2..16).
REQ-002 SHALL provide parameter WordAddr, default 1; 1 = Avalon address is word-addressed, 0 = byte-addressed.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 avs_address  input  32  Avalon slave address; avs_byteenable  input  4  byte lanes.
REQ-007 avs_read, avs_write  input  1 each  Avalon read/write strobes; avs_writedata  input  32  write data.
REQ-008 avs_waitrequest  output  1  stall; avs_readdata  output  32  read data; avs_readdatavalid  output  1  read data valid.
REQ-009 avs_response  output  2  00 OKAY, 10 SLVERR; valid with readdatavalid (or writeresponsevalid).
REQ-010 mem_req_o, mem_we_o  output  1 each; mem_be_o  output  4; mem_addr_o, mem_wdata_o  output  32  ibex-style request.
REQ-011 mem_gnt_i, mem_rvalid_i, mem_err_i  input  1 each; mem_rdata_i  input  32  ibex-style grant/response.
REQ-012 err_sticky_o  output  1  set on any mem_err_i response, cleared only by reset.

Function
REQ-013 mem_req_o SHALL equal (avs_read | avs_write) & ~full, combinationally; mem_we_o = avs_write & ~avs_read.
REQ-014 mem_addr_o SHALL be {avs_address[29:0],2'b00} when WordAddr=1, else {avs_address[31:2],2'b00}; be/wdata pass through.
REQ-015 avs_waitrequest SHALL be ~(mem_req_o & mem_gnt_i) while a strobe is high, and 1 when idle.
REQ-016 Acceptance (mem_req_o & mem_gnt_i) SHALL push transaction type (read/write) into an in-order tracking FIFO.
REQ-017 full SHALL assert when MaxOutstanding entries are held; no request issued while full.
REQ-018 Each mem_rvalid_i SHALL pop one FIFO entry; push and pop in same cycle leave count unchanged.
REQ-019 Popped read: avs_readdatavalid=1 next cycle, avs_readdata=registered mem_rdata_i, avs_response=10 if mem_err_i else 00.
REQ-020 Popped write SHALL produce no Avalon read response (posted write).
REQ-021 mem_rvalid_i with FIFO empty SHALL be ignored; no Avalon output changes, count stays 0.
REQ-022 avs_read & avs_write together SHALL be served as a read; the write is dropped.
REQ-023 Read latency SHALL be exactly mem rvalid latency + 1 cycle; back-to-back reads SHALL sustain one per cycle.
REQ-024 avs_readdata SHALL hold its last value when avs_readdatavalid=0.

Reset
REQ-025 Reset SHALL clear FIFO, count, err_sticky_o; avs_readdatavalid=0, avs_readdata=0, avs_response=00.
REQ-026 Reset mid-operation SHALL discard all outstanding entries; memory side shares rst_i, so later rvalids fall under REQ-021.

Configuration
REQ-027 Macro AVS_WRITE_RESP_EN defined: add output avs_writeresponsevalid (1 bit), pulsed one cycle after a popped write with avs_response per REQ-019 error rule.
REQ-028 AVS_WRITE_RESP_EN undefined: port absent; writes posted per REQ-020.
REQ-029 Read and write responses on the same cycle SHALL be impossible, since the FIFO pops once per cycle.

Structure
REQ-030 Package avalon_ibex_pkg SHALL hold avs_response_e (OKAY=2'b00, RESERVED=2'b01, SLVERR=2'b10, DECODEERROR=2'b11) and txn_type_e (TXN_READ, TXN_WRITE).
REQ-031 Tracking FIFO SHALL be sub-module avalon_ibex_txn_fifo (depth MaxOutstanding, push/pop/full/empty/count).

Verification
REQ-032 Single read addr 0x10 (WordAddr=1), gnt same cycle, rvalid 2 cycles later, rdata 0xDEADBEEF -> mem_addr_o=0x40; readdatavalid 3 cycles after accept, response 00.
REQ-033 Four reads, gnt every cycle, no rvalid -> fifth read sees waitrequest=1, mem_req_o=0 until first rvalid.
REQ-034 Write 0xCAFEF00D be=4'b0011 then read, rvalids in order -> only one readdatavalid, carrying the read's data.
REQ-035 Read with mem_err_i=1 on rvalid -> avs_response=10, err_sticky_o=1 and stays 1 after later OKAY reads.
REQ-036 Reset asserted with 2 reads outstanding, then 2 stray rvalids -> no readdatavalid, count 0.
REQ-037 With AVS_WRITE_RESP_EN, write then rvalid -> avs_writeresponsevalid pulse one cycle later, response 00.
